// File: rtl/rom_rr_arbiter.sv
// Two-requester req/ack front end for an async ROM: latch winner addr, hold WAIT_CYCLES, register rom_q, ack for one cycle.
// Latency WAIT_CYCLES+1 edges to ack; losers hold req until served; ROM_ARB_FIXED_PRIO_EN selects fixed priority to requester 0.
module rom_rr_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          win;
  logic [CW-1:0] cnt;

`ifdef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    win = ~req0;
  end
`else
  logic last;

  // On a tie the requester not served most recently wins.
  always_comb begin
    win = (req0 & req1) ? ~last : req1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last <= 1'b1;
    end else if (state == RESP) begin
      last <= owner;
    end
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = READ;
      READ:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    ack0 = (state == RESP) & ~owner;
    ack1 = (state == RESP) &  owner;
  end

  // rom_addr is only loaded in IDLE, so requester address changes mid-access are ignored.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rom_addr <= '0;
      owner    <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            rom_addr <= win ? addr1 : addr0;
            owner    <= win;
            cnt      <= CNT_LOAD;
          end
        end
        READ: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rdata <= rom_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3, each with its own ROM model.
module tb_rom_rr_arbiter;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       req0, req1;
  logic [2:0] addr0, addr1;
  logic       ack0, ack1, busy;
  logic [7:0] rdata, rom_q;
  logic [2:0] rom_addr;

  logic       req0_w, req1_w;
  logic [2:0] addr0_w, addr1_w;
  logic       ack0_w, ack1_w, busy_w;
  logic [7:0] rdata_w, rom_q_w;
  logic [2:0] rom_addr_w;

  logic [7:0] rom [0:7];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign rom_q   = rom[rom_addr];
  assign rom_q_w = rom[rom_addr_w];

  rom_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_CYCLES(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .rom_addr(rom_addr), .rom_q(rom_q)
  );

  rom_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_CYCLES(3)) dut_w3 (
    .CLK(CLK), .nRST(nRST),
    .req0(req0_w), .addr0(addr0_w), .req1(req1_w), .addr1(addr1_w),
    .ack0(ack0_w), .ack1(ack1_w), .rdata(rdata_w), .busy(busy_w),
    .rom_addr(rom_addr_w), .rom_q(rom_q_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Steps until either ack of the WAIT_CYCLES=1 instance pulses, bounded by max cycles.
  task automatic wait_ack(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(ack0 | ack1) && n < max);
    check("ack_seen", {31'b0, ack0 | ack1}, 32'd1);
    check("ack_excl", {31'b0, ack0 & ack1}, 32'd0);
  endtask

  initial begin
    int n;
    int prev_cyc;
    int who;
    rom[0] = 8'b10101010; rom[1] = 8'b11110000; rom[2] = 8'b00001111; rom[3] = 8'b11001100;
    rom[4] = 8'b11100111; rom[5] = 8'b00011000; rom[6] = 8'b10110111; rom[7] = 8'b11101101;
    nRST = 1'b0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    req0_w = 0; req1_w = 0; addr0_w = 0; addr1_w = 0;
    #3;
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_ack",   {30'b0, ack0, ack1}, 32'd0);
    check("rst_rdata", {24'b0, rdata}, 32'd0);
    check("rst_addr",  {29'b0, rom_addr}, 32'd0);
    check("rst_busy_w3", {31'b0, busy_w}, 32'd0);
    #5 nRST = 1'b1;
    step();

    // Single read, requester 0, address 3
    req0 = 1; addr0 = 3;
    wait_ack(10, n);
    check("single_lat",   n, 32'd2);
    check("single_ack0",  {31'b0, ack0}, 32'd1);
    check("single_ack1",  {31'b0, ack1}, 32'd0);
    check("single_rdata", {24'b0, rdata}, 32'hCC);
    req0 = 0;
    step();
    check("single_ack_drop", {31'b0, ack0}, 32'd0);
    check("single_idle",     {31'b0, busy}, 32'd0);

    // Sweep all addresses from requester 1, back to back
    prev_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      req1 = 1; addr1 = 3'(i);
      wait_ack(10, n);
      check("sweep_ack1",  {31'b0, ack1}, 32'd1);
      check("sweep_rdata", {24'b0, rdata}, {24'b0, rom[i]});
      if (i > 0) check("sweep_spacing", cyc - prev_cyc, 32'd3);
      prev_cyc = cyc;
      req1 = 0;
      step();
      check("sweep_single_cycle", {31'b0, ack1}, 32'd0);
    end

    // Contention: both held continuously after a fresh reset
    nRST = 0; #2 nRST = 1;
    step();
    req0 = 1; addr0 = 4; req1 = 1; addr1 = 6;
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      who = 0;
`else
      who = k % 2;
`endif
      wait_ack(6, n);
      check("cont_who",   {31'b0, ack1}, who);
      check("cont_rdata", {24'b0, rdata}, (who == 1) ? 32'hB7 : 32'hE7);
    end
    req0 = 0; req1 = 0;
    step();
    step();
    check("cont_idle", {31'b0, busy}, 32'd0);

    // WAIT_CYCLES=3 instance, requester 1 address 7; address change must be ignored
    req1_w = 1; addr1_w = 7;
    step();
    check("w3_addr_c0", {29'b0, rom_addr_w}, 32'd7);
    check("w3_busy",    {31'b0, busy_w}, 32'd1);
    addr1_w = 2;
    step();
    check("w3_addr_c1", {29'b0, rom_addr_w}, 32'd7);
    check("w3_noack_c1", {31'b0, ack1_w}, 32'd0);
    step();
    check("w3_addr_c2", {29'b0, rom_addr_w}, 32'd7);
    check("w3_noack_c2", {31'b0, ack1_w}, 32'd0);
    step();
    check("w3_ack1",  {31'b0, ack1_w}, 32'd1);
    check("w3_ack0",  {31'b0, ack0_w}, 32'd0);
    check("w3_rdata", {24'b0, rdata_w}, 32'hED);
    req1_w = 0;
    step();
    check("w3_ack_drop", {31'b0, ack1_w}, 32'd0);

    // Reset in the middle of READ
    req0 = 1; addr0 = 6;
    step();
    check("mid_busy_before", {31'b0, busy}, 32'd1);
    #2 nRST = 0;
    #1;
    check("mid_busy",  {31'b0, busy}, 32'd0);
    check("mid_rdata", {24'b0, rdata}, 32'd0);
    check("mid_addr",  {29'b0, rom_addr}, 32'd0);
    req0 = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_no_ack", {30'b0, ack0, ack1}, 32'd0);
    end
    nRST = 1;
    step();
    check("mid_still_idle", {31'b0, busy}, 32'd0);
    req0 = 1; addr0 = 2; req1 = 1; addr1 = 5;
    wait_ack(10, n);
    check("tie_after_rst_ack0", {31'b0, ack0}, 32'd1);
    check("tie_after_rst_data", {24'b0, rdata}, 32'h0F);
    req0 = 0; req1 = 0;
    step();

    // Address change during READ: address 5 must be used
    req0 = 1; addr0 = 5;
    step();
    check("chg_latched", {29'b0, rom_addr}, 32'd5);
    addr0 = 1;
    wait_ack(10, n);
    check("chg_lat",   n, 32'd1);
    check("chg_ack0",  {31'b0, ack0}, 32'd1);
    check("chg_rdata", {24'b0, rdata}, 32'h18);
    req0 = 0;
    step();

    // Request dropped mid-transaction still completes
    req1 = 1; addr1 = 2;
    step();
    req1 = 0;
    wait_ack(10, n);
    check("drop_ack1",  {31'b0, ack1}, 32'd1);
    check("drop_rdata", {24'b0, rdata}, 32'h0F);
    step();
    check("drop_idle", {31'b0, busy}, 32'd0);
    check("drop_noack", {30'b0, ack0, ack1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
